// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad entry block: the debounce FSM state
//   encoding, the two reserved command codes and the entry buffer depth.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no key in progress
    ST_CAND = 2'd1,  // collecting matching hits for a candidate key
    ST_HELD = 2'd2   // press accepted, waiting for release
  } key_state_e;

  localparam logic [3:0] KEY_ENTER  = 4'hE;
  localparam logic [3:0] KEY_CLEAR  = 4'hF;
  localparam logic [2:0] MAX_DIGITS = 3'd4;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Turns the sparse scanner hit flag into exactly one strobe per physical
//   key press. A press is accepted after STABLE_HITS consecutive hits of the
//   same code; the key is considered released after RELEASE_TICKS cycles
//   without any hit.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     key_in          scanner code, valid while key_pressed_in is high
//     key_pressed_in  scanner hit flag (a hit is its rising edge)
//     key_strobe      one-cycle pulse per accepted press
//     key_code        code of the last accepted press, held between strobes
//     debug_state     current debounce FSM state
//
//   Strobe semantics: key_strobe is a single-cycle event with no back
//   pressure; key_code is valid in the strobe cycle and stays put until the
//   next strobe, so a consumer may sample it in or after that cycle.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int STABLE_HITS   = 3,
  parameter int RELEASE_TICKS = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       key_pressed_in,
  output logic       key_strobe,
  output logic [3:0] key_code,
  output key_state_e debug_state
);

  localparam int SW = $clog2(RELEASE_TICKS + 1);
  localparam int HW = $clog2(STABLE_HITS + 1);
  localparam logic [SW-1:0] SILENCE_MAX = SW'(RELEASE_TICKS);
  // hits value at which one more matching hit accepts the press
  localparam logic [HW-1:0] HITS_LAST   = HW'(STABLE_HITS - 1);

  key_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [SW-1:0] silence_q;
  logic          pressed_q;
  logic          hit;
  logic          silence_full;
  logic          strobe_d;
  logic [3:0]    code_d;

  assign hit          = key_pressed_in & ~pressed_q;
  assign silence_full = (silence_q == SILENCE_MAX);
  assign debug_state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q  <= 1'b0;
      silence_q  <= '0;
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      hits_q     <= '0;
      key_strobe <= 1'b0;
      key_code   <= '0;
    end else begin
      pressed_q  <= key_pressed_in;
      if (hit)
        silence_q <= '0;
      else if (!silence_full)
        silence_q <= silence_q + 1'b1;
      state_q    <= state_d;
      cand_q     <= cand_d;
      hits_q     <= hits_d;
      key_strobe <= strobe_d;
      key_code   <= code_d;
    end
  end

  // A hit always wins over release: the register value may still read as
  // saturated in the cycle a new hit arrives.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    hits_d   = hits_q;
    strobe_d = 1'b0;
    code_d   = key_code;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          cand_d  = key_in;
          hits_d  = HW'(1);
          state_d = ST_CAND;
          if (STABLE_HITS <= 1) begin
            strobe_d = 1'b1;
            code_d   = key_in;
            hits_d   = '0;
            state_d  = ST_HELD;
          end
        end
      end
      ST_CAND: begin
        if (hit) begin
          if (key_in == cand_q) begin
            if (hits_q == HITS_LAST) begin
              strobe_d = 1'b1;
              code_d   = cand_q;
              hits_d   = '0;
              state_d  = ST_HELD;
            end else begin
              hits_d = hits_q + 1'b1;
            end
          end else begin
            // bounce to another key: restart counting on the new code
            cand_d = key_in;
            hits_d = HW'(1);
          end
        end else if (silence_full) begin
          hits_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        // hits only keep silence cleared here; no auto-repeat
        if (!hit && silence_full)
          state_d = ST_IDLE;
      end
      default: begin
        hits_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
//   Debounced hex keypad front end with a four-digit entry buffer.
//   Codes 0x0-0xD are digits shifted in at [3:0]; 0xE (ENTER) commits a
//   non-empty buffer to entry_value; 0xF (CLEAR) empties the buffer.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     key_in          scanner code
//     key_pressed_in  scanner hit flag
//     key_strobe      one-cycle pulse per accepted press
//     key_code        last accepted code
//     digits          entry buffer, newest digit in [3:0]
//     digit_count     digits held, 0..4
//     entry_done      one-cycle pulse on commit
//     entry_value     last committed entry
//     overflow        sticky, set when a digit arrives with a full buffer
//     debug_state     debounce FSM state
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int STABLE_HITS   = 3,
  parameter int RELEASE_TICKS = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_in,
  input  logic        key_pressed_in,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        entry_done,
  output logic [15:0] entry_value,
  output logic        overflow,
  output key_state_e  debug_state
);

  key_debounce #(
    .STABLE_HITS  (STABLE_HITS),
    .RELEASE_TICKS(RELEASE_TICKS)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_pressed_in(key_pressed_in),
    .key_strobe    (key_strobe),
    .key_code      (key_code),
    .debug_state   (debug_state)
  );

  // Buffer reacts to the registered strobe, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      digit_count <= '0;
      entry_done  <= 1'b0;
      entry_value <= '0;
      overflow    <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      if (key_strobe) begin
        if (key_code == KEY_CLEAR) begin
          digits      <= '0;
          digit_count <= '0;
          overflow    <= 1'b0;
        end else if (key_code == KEY_ENTER) begin
          if (digit_count != 3'd0) begin
            entry_value <= digits;
            entry_done  <= 1'b1;
            digits      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
          end
        end else if (digit_count < MAX_DIGITS) begin
          digits      <= {digits[11:0], key_code};
          digit_count <= digit_count + 3'd1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_in = 4'h0;
  logic        key_pressed_in = 1'b0;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        entry_done;
  logic [15:0] entry_value;
  logic        overflow;
  key_state_e  debug_state;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int s0;
  int d0;

  logic [3:0]  strobe_q[$];
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  keypad_entry #(
    .STABLE_HITS  (3),
    .RELEASE_TICKS(20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_pressed_in(key_pressed_in),
    .key_strobe    (key_strobe),
    .key_code      (key_code),
    .digits        (digits),
    .digit_count   (digit_count),
    .entry_done    (entry_done),
    .entry_value   (entry_value),
    .overflow      (overflow),
    .debug_state   (debug_state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n hits: flag high 2 cycles out of every 8
  task automatic press(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_in = k;
      key_pressed_in = 1'b1;
      tick(2);
      key_pressed_in = 1'b0;
      tick(6);
    end
  endtask

  task automatic accept(input logic [3:0] k);
    strobe_q.push_back(k);
    press(k, 3);
    tick(25);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt++;
      if (strobe_q.size() == 0) check("unexpected_strobe", {12'h0, key_code}, 16'hFFFF);
      else check("strobe_code", {12'h0, key_code}, {12'h0, strobe_q.pop_front()});
    end
    if (entry_done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_entry_done", entry_value, 16'hFFFF);
      else check("entry_value_at_done", digits, 16'h0000);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobe"}, {15'h0, key_strobe}, 16'h0);
    check({tag, "_code"}, {12'h0, key_code}, 16'h0);
    check({tag, "_digits"}, digits, 16'h0);
    check({tag, "_count"}, {13'h0, digit_count}, 16'h0);
    check({tag, "_done"}, {15'h0, entry_done}, 16'h0);
    check({tag, "_entry"}, entry_value, 16'h0);
    check({tag, "_ovf"}, {15'h0, overflow}, 16'h0);
    check({tag, "_state"}, {14'h0, debug_state}, {14'h0, ST_IDLE});
  endtask

  initial begin
    // reset state
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // key 5 held for 6 hits -> single strobe
    s0 = strobe_cnt;
    strobe_q.push_back(4'h5);
    press(4'h5, 6);
    check("held5_state", {14'h0, debug_state}, {14'h0, ST_HELD});
    tick(25);
    check("held5_strobes", 16'(strobe_cnt - s0), 16'd1);
    check("held5_code", {12'h0, key_code}, 16'h0005);
    check("held5_digits", digits, 16'h0005);
    check("held5_count", {13'h0, digit_count}, 16'd1);
    check("held5_released", {14'h0, debug_state}, {14'h0, ST_IDLE});

    // bounce: 3 then 7,7,7
    s0 = strobe_cnt;
    press(4'h3, 1);
    strobe_q.push_back(4'h7);
    press(4'h7, 3);
    tick(25);
    check("bounce_strobes", 16'(strobe_cnt - s0), 16'd1);
    check("bounce_digits", digits, 16'h0057);
    accept(KEY_CLEAR);
    check("clear1_digits", digits, 16'h0000);
    check("clear1_count", {13'h0, digit_count}, 16'd0);

    // fill, overflow, enter
    accept(4'h1);
    accept(4'h2);
    accept(4'h3);
    accept(4'h4);
    check("full_ovf_before", {15'h0, overflow}, 16'h0);
    accept(4'h9);
    check("full_digits", digits, 16'h1234);
    check("full_count", {13'h0, digit_count}, 16'd4);
    check("full_ovf", {15'h0, overflow}, 16'h1);
    d0 = done_cnt;
    exp_q.push_back(16'h1234);
    accept(KEY_ENTER);
    check("enter_pulses", 16'(done_cnt - d0), 16'd1);
    if (exp_q.size() != 0) check("enter_value", entry_value, exp_q.pop_front());
    check("enter_value_held", entry_value, 16'h1234);
    check("enter_digits", digits, 16'h0000);
    check("enter_count", {13'h0, digit_count}, 16'd0);
    check("enter_ovf", {15'h0, overflow}, 16'h0);

    // enter on empty buffer, then A B CLEAR
    d0 = done_cnt;
    accept(KEY_ENTER);
    check("empty_enter_pulses", 16'(done_cnt - d0), 16'd0);
    accept(4'hA);
    accept(4'hB);
    check("ab_digits", digits, 16'h00AB);
    accept(KEY_CLEAR);
    check("clear2_digits", digits, 16'h0000);
    check("clear2_count", {13'h0, digit_count}, 16'd0);
    check("clear2_entry", entry_value, 16'h1234);
    check("clear2_pulses", 16'(done_cnt - d0), 16'd0);

    // another key while HELD is ignored until release
    s0 = strobe_cnt;
    strobe_q.push_back(4'h8);
    press(4'h8, 3);
    press(4'h6, 3);
    check("held_other_strobes", 16'(strobe_cnt - s0), 16'd1);
    check("held_other_state", {14'h0, debug_state}, {14'h0, ST_HELD});
    tick(25);
    accept(4'h6);
    check("held_other_total", 16'(strobe_cnt - s0), 16'd2);
    check("held_other_digits", digits, 16'h0086);

    // reset mid-press discards the press
    s0 = strobe_cnt;
    press(4'h4, 2);
    rst = 1'b1;
    press(4'h4, 1);
    check_outputs_zero("midrst");
    rst = 1'b0;
    tick(1);
    check("midrst_strobes", 16'(strobe_cnt - s0), 16'd0);
    press(4'h4, 2);
    check("post_rst_two_hits", 16'(strobe_cnt - s0), 16'd0);
    strobe_q.push_back(4'h4);
    press(4'h4, 1);
    tick(25);
    check("post_rst_strobes", 16'(strobe_cnt - s0), 16'd1);
    check("post_rst_digits", digits, 16'h0004);
    check("post_rst_count", {13'h0, digit_count}, 16'd1);

    // scoreboard drained
    check("strobe_q_empty", 16'(strobe_q.size()), 16'd0);
    check("exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
